// File: rtl/user_core_io_mux_pkg.sv
// Shared definitions for user_core_io_mux: register offsets, PAD_SEL layout and
// the per-core reset state encoding. Offsets are Wishbone word offsets (adr[7:2]).
package user_core_io_mux_pkg;

    localparam logic [5:0] CORE_RST_OFF = 6'h00;  // byte 0x00
    localparam logic [5:0] STATUS_OFF   = 6'h01;  // byte 0x04
    localparam logic [5:0] PAD_SEL_BASE = 6'h04;  // byte 0x10, four pads per word

    localparam int unsigned OWNER_W   = 4;
    localparam int unsigned FORCE_BIT = 7;
    localparam int unsigned MAX_CORES = 16;

    typedef struct packed {
        logic               force_in;
        logic [2:0]         rsvd;
        logic [OWNER_W-1:0] owner;
    } pad_sel_t;

    typedef enum logic {
        RST_HOLD = 1'b0,
        RST_RUN  = 1'b1
    } rst_state_t;

endpackage

// File: rtl/user_core_io_mux_core_rst.sv
// core_rst_stretch: per-core reset generator. Holds rst_o high for RST_STRETCH
// cycles after the bus reset or after a software restart pulse.
module core_rst_stretch
    import user_core_io_mux_pkg::*;
#(
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic rst_o
);

    localparam int unsigned CNT_W = $clog2(RST_STRETCH + 1);

    rst_state_t       state;
    logic [CNT_W-1:0] cnt;

    // HOLD counts down to zero then releases; a restart reloads from either state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_HOLD;
            cnt   <= CNT_W'(RST_STRETCH);
            rst_o <= 1'b1;
        end else if (restart) begin
            state <= RST_HOLD;
            cnt   <= CNT_W'(RST_STRETCH);
            rst_o <= 1'b1;
        end else if (state == RST_HOLD) begin
            if (cnt <= CNT_W'(1)) begin
                state <= RST_RUN;
                cnt   <= '0;
                rst_o <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/user_core_io_mux.sv
// user_core_io_mux: arbitrates NUM_CORES user cores onto the Caravel pads.
// Pad ownership and per-core resets are software controlled over Wishbone.
// Optional build macro: LA_OVERRIDE_EN (logic-analyzer pad override and
// core reset visibility on la_data_out).
module user_core_io_mux
    import user_core_io_mux_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned NUM_IO      = 38,
    parameter int unsigned RST_STRETCH = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic [31:0]                 wbs_dat_o,
    output logic                        wbs_ack_o,
    input  logic [NUM_CORES*NUM_IO-1:0] core_io_out,
    input  logic [NUM_CORES*NUM_IO-1:0] core_io_oeb,
    output logic [NUM_CORES-1:0]        core_rst_o,
    output logic [NUM_IO-1:0]           io_out,
    output logic [NUM_IO-1:0]           io_oeb,
    input  logic [127:0]                la_data_in,
    input  logic [127:0]                la_oenb,
    output logic [127:0]                la_data_out
);

    logic                 sel;
    logic                 wr_commit;
    logic [5:0]           offset;
    logic [31:0]          wmask;
    logic [31:0]          rdata;
    logic [NUM_CORES-1:0] rst_req;
    pad_sel_t             pad_sel [NUM_IO];
    logic [NUM_IO-1:0]    out_arr [MAX_CORES];
    logic [NUM_IO-1:0]    oeb_arr [MAX_CORES];
    logic                 unused_sink;

    assign sel       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign offset    = wbs_adr_i[7:2];
    // The master still holds the request during the ack cycle; commit then.
    assign wr_commit = sel & wbs_ack_o & wbs_we_i;

    // Expand byte selects to a bit mask.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) begin
            wmask[b*8 +: 8] = {8{wbs_sel_i[b]}};
        end
    end

    // Read mux over the register map; unmapped and write-only words read 0.
    always_comb begin
        rdata = '0;
        if (offset == STATUS_OFF) begin
            rdata = 32'(core_rst_o);
        end
        for (int p = 0; p < NUM_IO; p++) begin
            if (offset == 6'(PAD_SEL_BASE + p / 4)) begin
                rdata[(p % 4)*8 +: 8] = pad_sel[p];
            end
        end
    end

    // Single-cycle ack, forced low after each ack; read data valid with ack only.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= sel & ~wbs_ack_o;
            wbs_dat_o <= (sel & ~wbs_ack_o) ? rdata : '0;
        end
    end

    // PAD_SEL storage, byte-granular writes; reserved bits always stored as 0.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int p = 0; p < NUM_IO; p++) begin
                pad_sel[p] <= '0;
            end
        end else if (wr_commit) begin
            for (int p = 0; p < NUM_IO; p++) begin
                if ((offset == 6'(PAD_SEL_BASE + p / 4)) && wbs_sel_i[p % 4]) begin
                    pad_sel[p].owner    <= wbs_dat_i[(p % 4)*8 +: OWNER_W];
                    pad_sel[p].rsvd     <= '0;
                    pad_sel[p].force_in <= wbs_dat_i[(p % 4)*8 + FORCE_BIT];
                end
            end
        end
    end

    assign rst_req = (wr_commit && (offset == CORE_RST_OFF))
                   ? (wbs_dat_i[NUM_CORES-1:0] & wmask[NUM_CORES-1:0])
                   : '0;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        core_rst_stretch #(
            .RST_STRETCH(RST_STRETCH)
        ) u_rst (
            .clk     (wb_clk_i),
            .rst     (wb_rst_i),
            .restart (rst_req[c]),
            .rst_o   (core_rst_o[c])
        );
    end

    // Full 16-entry slice tables; owners without a core see a released pad.
    for (genvar c = 0; c < MAX_CORES; c++) begin : g_slice
        if (c < NUM_CORES) begin : g_on
            assign out_arr[c] = core_io_out[c*NUM_IO +: NUM_IO];
            assign oeb_arr[c] = core_io_oeb[c*NUM_IO +: NUM_IO];
        end else begin : g_off
            assign out_arr[c] = '0;
            assign oeb_arr[c] = '1;
        end
    end

    // Pad mux from the registered ownership table.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int p = 0; p < NUM_IO; p++) begin
            if (!pad_sel[p].force_in) begin
                io_out[p] = out_arr[pad_sel[p].owner][p];
                io_oeb[p] = oeb_arr[pad_sel[p].owner][p];
            end
`ifdef LA_OVERRIDE_EN
            if (!la_oenb[p]) begin
                io_out[p] = la_data_in[p];
                io_oeb[p] = 1'b0;
            end
`endif
        end
    end

`ifdef LA_OVERRIDE_EN
    assign la_data_out = 128'(core_rst_o);
`else
    assign la_data_out = '0;
`endif

    // Bits that carry no function in some builds.
    assign unused_sink = ^{wbs_adr_i[1:0], wbs_dat_i, la_data_in, la_oenb};

endmodule

// File: tb/tb_user_core_io_mux.sv
// Self-checking bench for user_core_io_mux: directed register/reset cases plus
// random Wishbone traffic and random core pad activity against a reference model.
`timescale 1ns/1ps
module tb_user_core_io_mux;

    localparam int NC   = 2;
    localparam int NIO  = 38;
    localparam int RS   = 16;
    localparam int CW   = NC * NIO;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic          wbs_cyc_i = 1'b0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = '0;
    logic [31:0]   wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic [CW-1:0] core_io_out = '0;
    logic [CW-1:0] core_io_oeb = '0;
    logic [NC-1:0] core_rst_o;
    logic [NIO-1:0] io_out;
    logic [NIO-1:0] io_oeb;
    logic [127:0]  la_data_in = '0;
    logic [127:0]  la_oenb = '1;
    logic [127:0]  la_data_out;

    always #5 wb_clk_i = ~wb_clk_i;

    user_core_io_mux #(
        .NUM_CORES(NC), .NUM_IO(NIO), .RST_STRETCH(RS), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .core_io_out(core_io_out), .core_io_oeb(core_io_oeb), .core_rst_o(core_rst_o),
        .io_out(io_out), .io_oeb(io_oeb),
        .la_data_in(la_data_in), .la_oenb(la_oenb), .la_data_out(la_data_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_owner [NIO];
    bit  m_force [NIO];
    int  m_rem   [NC];   // clock edges left before core reset drops

    // write handoff from the bus task to the model (single writer per variable)
    int          pend_req = 0;
    int          pend_done = 0;
    logic [31:0] pend_adr, pend_dat;
    logic [3:0]  pend_sel;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        bit [NC-1:0] rs;
        int off, p;
        if (wb_rst_i) begin
            for (int i = 0; i < NIO; i++) begin m_owner[i] = 0; m_force[i] = 0; end
            for (int c = 0; c < NC; c++) m_rem[c] = RS;
            pend_done = pend_req;
        end else begin
            rs = '0;
            if (pend_req != pend_done) begin
                pend_done = pend_req;
                off = int'(pend_adr[7:2]);
                if (off == 0) begin
                    for (int c = 0; c < NC; c++)
                        if (pend_dat[c] && pend_sel[c/8]) rs[c] = 1'b1;
                end else if (off >= 4) begin
                    for (int b = 0; b < 4; b++) begin
                        p = (off - 4) * 4 + b;
                        if (pend_sel[b] && p < NIO) begin
                            m_owner[p] = int'(pend_dat[b*8 +: 4]);
                            m_force[p] = pend_dat[b*8 + 7];
                        end
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (rs[c]) m_rem[c] = RS;
                else if (m_rem[c] > 0) m_rem[c]--;
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        logic [31:0] r;
        int off, p;
        r = '0;
        off = int'(adr[7:2]);
        if (off == 1) begin
            for (int c = 0; c < NC; c++) r[c] = (m_rem[c] > 0);
        end else if (off >= 4) begin
            for (int b = 0; b < 4; b++) begin
                p = (off - 4) * 4 + b;
                if (p < NIO) begin
                    r[b*8 +: 4] = 4'(m_owner[p]);
                    r[b*8 + 7]  = m_force[p];
                end
            end
        end
        return r;
    endfunction

    // ---------------- per-cycle pad stimulus and checks ----------------
    bit           chk_en = 0;
    bit           la_rand = 1;
    logic [127:0] la_dat_dir = '0;
    logic [127:0] la_oenb_dir = '1;

    initial begin
        logic [NIO-1:0] eo, ee;
        logic [127:0]   el;
        forever begin
            @(negedge wb_clk_i);
            core_io_out = CW'({$urandom(), $urandom(), $urandom()});
            core_io_oeb = CW'({$urandom(), $urandom(), $urandom()});
            if (la_rand) begin
                la_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                la_oenb    = ~({$urandom(), $urandom(), $urandom(), $urandom()} &
                               {$urandom(), $urandom(), $urandom(), $urandom()});
            end else begin
                la_data_in = la_dat_dir;
                la_oenb    = la_oenb_dir;
            end
            #1;
            if (chk_en) begin
                el = '0;
                for (int p = 0; p < NIO; p++) begin
                    if (m_force[p] || m_owner[p] >= NC) begin
                        eo[p] = 1'b0; ee[p] = 1'b1;
                    end else begin
                        eo[p] = core_io_out[m_owner[p]*NIO + p];
                        ee[p] = core_io_oeb[m_owner[p]*NIO + p];
                    end
`ifdef LA_OVERRIDE_EN
                    if (!la_oenb[p]) begin eo[p] = la_data_in[p]; ee[p] = 1'b0; end
`endif
                end
                for (int c = 0; c < NC; c++) begin
`ifdef LA_OVERRIDE_EN
                    el[c] = (m_rem[c] > 0);
`endif
                    check_eq($sformatf("core_rst[%0d]", c), 128'(core_rst_o[c]), 128'(m_rem[c] > 0));
                end
                check_eq("io_out", 128'(io_out), 128'(eo));
                check_eq("io_oeb", 128'(io_oeb), 128'(ee));
                check_eq("la_data_out", la_data_out, el);
            end
        end
    end

    // ---------------- Wishbone access task ----------------
    task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                           input logic [3:0] sel, input bit exp_ack, output logic [31:0] rd);
        logic [31:0] exp_rd;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        exp_rd = model_read(adr);
        @(posedge wb_clk_i); #1;
        check_eq("ack_latency", 128'(wbs_ack_o), 128'(exp_ack));
        rd = wbs_dat_o;
        if (exp_ack && !we) check_eq("read_data", 128'(wbs_dat_o), 128'(exp_rd));
        if (!exp_ack) check_eq("dat_idle", 128'(wbs_dat_o), 128'(0));
        if (exp_ack && we) begin
            pend_adr = adr; pend_dat = dat; pend_sel = sel;
            pend_req++;
        end
        @(posedge wb_clk_i); #1;
        if (exp_ack) begin
            check_eq("ack_one_cycle", 128'(wbs_ack_o), 128'(0));
            check_eq("dat_after_ack", 128'(wbs_dat_o), 128'(0));
        end else begin
            check_eq("no_ack", 128'(wbs_ack_o), 128'(0));
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] adr;
        bit          ok;
        #2 wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_eq("rst_ack", 128'(wbs_ack_o), 128'(0));
        check_eq("rst_dat", 128'(wbs_dat_o), 128'(0));
        check_eq("rst_core_rst", 128'(core_rst_o), 128'(2'b11));
        wb_rst_i = 1'b0;
        chk_en = 1;

        // reset stretch after release
        repeat (15) @(posedge wb_clk_i);
        #1 check_eq("stretch_15", 128'(core_rst_o), 128'(2'b11));
        @(posedge wb_clk_i);
        #1 check_eq("stretch_16", 128'(core_rst_o), 128'(2'b00));

        // pad 0 to core 1, readback
        wb_xfer(BASE + 32'h10, 1'b1, 32'h0000_0001, 4'b0001, 1'b1, rd);
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b1, rd);
        check_eq("pad0_readback", 128'(rd), 128'(32'h0000_0001));

        // byte-lane write: pad 2 forced, owner 15
        wb_xfer(BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'b0100, 1'b1, rd);
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b1, rd);
        check_eq("pad2_readback", 128'(rd), 128'(32'h008F_0001));
        @(negedge wb_clk_i); #2;
        check_eq("pad2_oeb", 128'(io_oeb[2]), 128'(1));
        check_eq("pad2_out", 128'(io_out[2]), 128'(0));

        // software restart of core 1, then extension
        wb_xfer(BASE + 32'h00, 1'b1, 32'h0000_0002, 4'hF, 1'b1, rd);
        wb_xfer(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 1'b1, rd);
        check_eq("status_hold", 128'(rd), 128'(32'h2));
        wb_xfer(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 1'b1, rd);
        check_eq("core_rst_reads0", 128'(rd), 128'(0));
        wb_xfer(BASE + 32'h00, 1'b1, 32'h0000_0002, 4'hF, 1'b1, rd);
        repeat (15) @(posedge wb_clk_i);
        #1 check_eq("extend_15", 128'(core_rst_o), 128'(2'b10));
        @(posedge wb_clk_i);
        #1 check_eq("extend_16", 128'(core_rst_o), 128'(2'b00));

        // unmapped offset and foreign page
        wb_xfer(BASE + 32'h80, 1'b0, 32'h0, 4'hF, 1'b1, rd);
        check_eq("unmapped_zero", 128'(rd), 128'(0));
        wb_xfer(BASE + 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, rd);

        // held strobe is acked every other cycle
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h04; wbs_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i); #1;
            check_eq("held_ack", 128'(wbs_ack_o), 128'(i % 2 == 0));
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

`ifdef LA_OVERRIDE_EN
        // LA override beats force_in on pad 5
        wb_xfer(BASE + 32'h14, 1'b1, 32'h0000_8000, 4'b0010, 1'b1, rd);
        la_oenb_dir = '1; la_oenb_dir[5] = 1'b0;
        la_dat_dir  = '0; la_dat_dir[5]  = 1'b1;
        la_rand = 0;
        @(negedge wb_clk_i); #2;
        check_eq("la_pad5_oeb", 128'(io_oeb[5]), 128'(0));
        check_eq("la_pad5_out", 128'(io_out[5]), 128'(1));
        la_rand = 1;
`endif

        // random register traffic
        for (int t = 0; t < 80; t++) begin
            ok  = ($urandom_range(0, 9) != 0);
            adr = (ok ? BASE : (BASE + 32'h100)) | (32'($urandom_range(0, 20)) << 2);
            wb_xfer(adr, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom()), ok, rd);
            repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
        end
        repeat (20) @(posedge wb_clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
